cntr_updn_mod: RTL
==================

// Module: cntr_updn_mod
// PURPOSE
//   Parametrised up/down counter; successor to the fixed 4-bit up/down counter.
//   Adds programmable width and modulus, wrap or saturate mode, count enable,
//   synchronous clear and parallel load, and registered wrap/limit flags.
//   General-purpose timing/sequencing counter; cascadable via en + wrap.
// PARAMETERS
//   WIDTH     4            counter width in bits (>=1)
//   MAX_VAL   2**WIDTH-1   top count; range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
//   MODE      CNT_WRAP     CNT_WRAP: wrap at range ends; CNT_SAT: hold at ends
//   RST_VAL   0            value of q after reset (must be <= MAX_VAL)
// PORTS
//   clk     in   1      clock, rising edge
//   reset   in   1      asynchronous, active-low reset
//   en      in   1      count enable
//   ud      in   1      direction: 1 = up, 0 = down
//   clr     in   1      synchronous clear to 0
//   load    in   1      synchronous parallel load of d
//   d       in   WIDTH  load value
//   q       out  WIDTH  current count
//   wrap    out  1      1-cycle pulse: count wrapped (WRAP) or hit end (SAT)
//   at_lim  out  1      q == MAX_VAL when ud=1, q == 0 when ud=0 (combinational)
// BEHAVIOUR
//   - reset low (async, any time): q=RST_VAL, wrap=0 immediately; held while low.
//   - Priority per edge: clr > load > en. No action if none asserted; q holds.
//   - clr: q<=0, wrap<=0.
//   - load: q<=min(d, MAX_VAL) (out-of-range d clamps), wrap<=0.
//   - en, ud=1: q<MAX_VAL -> q+1; q==MAX_VAL -> WRAP: q<=0, wrap<=1; SAT: hold, wrap<=0.
//   - en, ud=0: q>0 -> q-1; q==0 -> WRAP: q<=MAX_VAL, wrap<=1; SAT: hold, wrap<=0.
//   - SAT: wrap<=1 on the edge where q reaches the end (MAX_VAL up / 0 down).
//   - wrap is registered, high exactly one cycle per event; 0 on idle cycles.
//   - Latency: q updates on the same clock edge; wrap is coincident with new q.
//   - ud may change any cycle; takes effect on the next edge, no dead cycle.
//   - Arithmetic in WIDTH+1 bits internally; q never leaves 0..MAX_VAL.
//   - MAX_VAL==0: q stays 0; WRAP pulses wrap on every enabled cycle.
//   - Reset deasserting mid-count resumes counting from RST_VAL on next edge.
// STRUCTURE
//   - Package cntr_pkg: typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e.
//   - Sub-module cntr_next: combinational next-count + wrap-event logic
//     (inputs q, ud, mode, MAX_VAL); top holds priority mux and registers.
//   - Elaboration-time assertions: MAX_VAL < 2**WIDTH, RST_VAL <= MAX_VAL.
// TESTING
//   1 WIDTH=4,MAX_VAL=15,WRAP, en=1,ud=1 from 0, 16 clks -> q 1..15,0; wrap=1
//     only on cycle q=0.
//   2 WIDTH=4,MAX_VAL=9,WRAP, ud=0 from 0 -> q=9, wrap pulse; continue down to 0.
//   3 MAX_VAL=9,SAT, ud=1 from 7 -> 8,9 (wrap=1),9,9 (wrap=0); flip ud=0 -> 8.
//   4 load=1,d=12 with MAX_VAL=9 -> q=9; clr=1 and load=1 together -> q=0.
//   5 reset low mid-count (q=5, between edges) -> q=RST_VAL at once, wrap=0;
//     release -> counting resumes next edge.
//   6 en toggled 1/0 every cycle, ud=1 -> q advances on enabled cycles only.

Source files
------------

// File: rtl/cntr_pkg.sv
// Shared types for the parametrised up/down counter.
package cntr_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/cntr_next.sv
// Next-count and wrap/end-event logic for one counting step in the current direction.
module cntr_next
  import cntr_pkg::*;
#(
  parameter int        WIDTH   = 4,
  parameter int        MAX_VAL = 2**WIDTH-1,
  parameter cnt_mode_e MODE    = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ud,
  output logic [WIDTH-1:0] nxt,
  output logic             evt
);

  localparam logic [WIDTH:0] LIM = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] qx;
  logic [WIDTH:0] sum;

  assign qx = {1'b0, q};

  // The extra top bit keeps the +1/-1 result from aliasing before the range compare.
  always_comb begin
    nxt = q;
    evt = 1'b0;
    sum = '0;
    if (ud) begin
      if (qx >= LIM) begin
        if (MODE == CNT_WRAP) begin
          nxt = '0;
          evt = 1'b1;
        end
      end else begin
        sum = qx + ONE;
        nxt = sum[WIDTH-1:0];
        evt = (MODE == CNT_SAT) && (sum == LIM);
      end
    end else begin
      if (qx == '0) begin
        if (MODE == CNT_WRAP) begin
          nxt = LIM[WIDTH-1:0];
          evt = 1'b1;
        end
      end else begin
        sum = qx - ONE;
        nxt = sum[WIDTH-1:0];
        evt = (MODE == CNT_SAT) && (sum == '0);
      end
    end
  end

endmodule

// File: rtl/cntr_updn_mod.sv
// Parametrised up/down counter with wrap/saturate modes, clear, load and registered wrap flag.
module cntr_updn_mod
  import cntr_pkg::*;
#(
  parameter int        WIDTH   = 4,
  parameter int        MAX_VAL = 2**WIDTH-1,
  parameter cnt_mode_e MODE    = CNT_WRAP,
  parameter int        RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ud,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             at_lim
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  if (MAX_VAL < 0 || longint'(MAX_VAL) > (longint'(1) << WIDTH) - 1) begin : g_bad_max
    $error("cntr_updn_mod: MAX_VAL must lie in 0..2**WIDTH-1");
  end
  if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("cntr_updn_mod: RST_VAL must lie in 0..MAX_VAL");
  end

  logic [WIDTH-1:0] nxt;
  logic             evt;

  cntr_next #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL),
    .MODE   (MODE)
  ) u_next (
    .q  (q),
    .ud (ud),
    .nxt(nxt),
    .evt(evt)
  );

  // clr beats load beats en; wrap only survives one edge because every other path clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= (d > MAX_Q) ? MAX_Q : d;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= nxt;
      wrap <= evt;
    end else begin
      wrap <= 1'b0;
    end
  end

  assign at_lim = ud ? (q == MAX_Q) : (q == '0);

endmodule
